// File: rtl/descrambler_scheduler.sv
// ---------------------------------------------------------------------------
// descrambler_scheduler: round-robin shared 8-bit additive descrambler with
// per-channel LFSR context.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module descrambler_scheduler #(
  parameter int         NUM_CH = 4,
  parameter logic [7:0] SEED   = 8'hFF,
  parameter int         CHW    = $clog2(NUM_CH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     req,
  input  logic [8*NUM_CH-1:0]   din,
  input  logic [NUM_CH-1:0]     resync,
  output logic [NUM_CH-1:0]     gnt,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  output logic [CHW-1:0]        dout_ch
);

  logic [7:0]     ctx_q [NUM_CH];
  logic [7:0]     ctx_d [NUM_CH];
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [7:0]     dout_q, dout_d;
  logic           dout_valid_q;
  logic [CHW-1:0] dout_ch_q, dout_ch_d;

  logic           found;
  logic [CHW-1:0] sel;
  logic [7:0]     cur;

  // Modular add for non-power-of-two channel counts.
  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[CHW-1:0];
  endfunction

  always_comb begin
    found = 1'b0;
    sel   = '0;
    if (enable && resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[wrap_add(ptr_q, i)]) begin
          found = 1'b1;
          sel   = wrap_add(ptr_q, i);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[sel] = 1'b1;
  end

  // A resync coincident with the grant makes this byte use SEED.
  assign cur = resync[sel] ? SEED : ctx_q[sel];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ctx_d[c] = resync[c] ? SEED : ctx_q[c];
    end
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    if (found) begin
      ctx_d[sel] = {cur[6:0], cur[6] ^ cur[3]};
      ptr_d      = wrap_add(sel, 1);
      dout_d     = cur ^ din[{sel, 3'b000} +: 8];
      dout_ch_d  = sel;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) ctx_q[c] <= SEED;
      ptr_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_ch_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) ctx_q[c] <= ctx_d[c];
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= found;
      dout_ch_q    <= dout_ch_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_ch    = dout_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_descrambler_scheduler.sv
// ---------------------------------------------------------------------------
// tb_descrambler_scheduler: scoreboard bench for descrambler_scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_descrambler_scheduler;
  localparam int         NUM_CH = 4;
  localparam int         CHW    = 2;
  localparam logic [7:0] SEED   = 8'hFF;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                enable = 1'b0;
  logic [NUM_CH-1:0]   req = '0;
  logic [8*NUM_CH-1:0] din = '0;
  logic [NUM_CH-1:0]   resync = '0;
  logic [NUM_CH-1:0]   gnt;
  logic [7:0]          dout;
  logic                dout_valid;
  logic [CHW-1:0]      dout_ch;

  int checks = 0;
  int failures = 0;

  logic [CHW+7:0] sb[$];
  logic [7:0]     m_ctx [NUM_CH];
  int             m_ptr;

  descrambler_scheduler #(.NUM_CH(NUM_CH), .SEED(SEED)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .req(req), .din(din),
    .resync(resync), .gnt(gnt), .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] lfsr(input logic [7:0] c);
    return {c[6:0], c[6] ^ c[3]};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) m_ctx[c] = SEED;
    m_ptr = 0;
    sb.delete();
  endfunction

  // Scoreboard consumer: every valid output must match the oldest prediction.
  always @(posedge clock) begin
    logic [CHW+7:0] e;
    #1;
    if (resetn && dout_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got ch=%0d dout=%h, none expected", dout_ch, dout);
      end else begin
        e = sb.pop_front();
        if ({dout_ch, dout} !== e) begin
          failures++;
          $display("FAIL sb_data got ch=%0d dout=%h expected ch=%0d dout=%h",
                   dout_ch, dout, e[CHW+7:8], e[7:0]);
        end
      end
    end
  end

  // Drive one cycle at the falling edge and run the reference model for it.
  task automatic drive(input logic en, input logic [NUM_CH-1:0] rq,
                       input logic [8*NUM_CH-1:0] d, input logic [NUM_CH-1:0] rs,
                       output logic [NUM_CH-1:0] eg);
    int k;
    logic [7:0] cur;
    logic [CHW-1:0] kc;
    @(negedge clock);
    enable = en; req = rq; din = d; resync = rs;
    eg = '0;
    k = -1;
    if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (k < 0 && rq[(m_ptr + i) % NUM_CH]) k = (m_ptr + i) % NUM_CH;
      end
    end
    for (int c = 0; c < NUM_CH; c++) if (c != k && rs[c]) m_ctx[c] = SEED;
    if (k >= 0) begin
      kc = k[CHW-1:0];
      cur = rs[k] ? SEED : m_ctx[k];
      sb.push_back({kc, cur ^ d[8*k +: 8]});
      m_ctx[k] = lfsr(cur);
      m_ptr = (k + 1) % NUM_CH;
      eg[k] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; req = '0; resync = '0; enable = 1'b0;
    #2;
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] eg;
    resetn = 1'b0;
    enable = 1'b1;
    req = NUM_CH'($urandom);
    din = $urandom;
    resync = NUM_CH'($urandom);
    model_reset();
    #12;
    checks++;
    if ({dout, dout_valid, gnt, dout_ch} !== '0) begin
      failures++;
      $display("FAIL reset_values got dout=%h v=%b gnt=%b ch=%0d required all zero",
               dout, dout_valid, gnt, dout_ch);
    end
    @(negedge clock);
    req = '0; resync = '0;
    resetn = 1'b1;
    drive(1'b1, 4'b0001, '0, '0, eg);
    checks++;
    if (gnt !== eg) begin failures++; $display("FAIL reset_first_gnt got %b required %b", gnt, eg); end
    @(posedge clock); #2;
    checks++;
    if (dout !== 8'hFF || dout_valid !== 1'b1) begin
      failures++; $display("FAIL reset_first_byte got %h/%b required FF/1", dout, dout_valid);
    end
  endtask

  task automatic test_single();
    logic [NUM_CH-1:0] eg;
    logic [7:0] exp_b [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 4'b0100, '0, '0, eg);
      checks++;
      if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt[%0d] got %b required 0100", n, gnt); end
      @(posedge clock); #2;
      checks++;
      if (dout !== exp_b[n] || dout_ch !== 2'd2) begin
        failures++;
        $display("FAIL single_byte[%0d] got %h ch=%0d required %h ch=2", n, dout, dout_ch, exp_b[n]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_CH-1:0] eg;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 4'b1111, '0, '0, eg);
      checks++;
      if (gnt !== eg || gnt !== (4'b0001 << (n % 4))) begin
        failures++; $display("FAIL rr_gnt[%0d] got %b required %b", n, gnt, 4'b0001 << (n % 4));
      end
      @(posedge clock); #2;
      checks++;
      if (dout !== ((n < 4) ? 8'hFF : 8'hFE)) begin
        failures++; $display("FAIL rr_byte[%0d] got %h required %h", n, dout, (n < 4) ? 8'hFF : 8'hFE);
      end
    end
  endtask

  task automatic test_resync();
    logic [NUM_CH-1:0] eg;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 4'b1111, 32'h0, (n == 12) ? 4'b0001 : 4'b0000, eg);
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL resync_gnt[%0d] got %b required %b", n, gnt, eg); end
      @(posedge clock); #2;
      if (n == 12 || n == 16 || n == 13) begin
        checks++;
        if (dout !== ((n == 12) ? 8'hFF : (n == 16) ? 8'hFE : 8'hF8)) begin
          failures++;
          $display("FAIL resync_byte[%0d] got %h required %h", n, dout,
                   (n == 12) ? 8'hFF : (n == 16) ? 8'hFE : 8'hF8);
        end
      end
    end
  endtask

  task automatic test_enable_pause();
    logic [NUM_CH-1:0] eg;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 4'b1111, 32'h5A3C_0F81, '0, eg);
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL pre_pause_gnt[%0d] got %b required %b", n, gnt, eg); end
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 4'b1111, 32'h5A3C_0F81, (n == 1) ? 4'b0010 : 4'b0000, eg);
      checks++;
      if (gnt !== 4'b0000) begin failures++; $display("FAIL pause_gnt[%0d] got %b required 0000", n, gnt); end
      @(posedge clock); #2;
      checks++;
      if (dout_valid !== 1'b0) begin failures++; $display("FAIL pause_valid[%0d] got %b required 0", n, dout_valid); end
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 4'b1111, '0, '0, eg);
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL resume_gnt[%0d] got %b required %b", n, gnt, eg); end
      if (n == 0) begin
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL resume_first got %b required 0010", gnt); end
        @(posedge clock); #2;
        checks++;
        if (dout !== 8'hFF) begin failures++; $display("FAIL resume_resynced got %h required FF", dout); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_CH-1:0] eg;
    for (int n = 0; n < 3; n++) drive(1'b1, 4'b1111, 32'h1234_5678, '0, eg);
    drive(1'b1, 4'b1111, 32'h1234_5678, '0, eg);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, gnt, dout_ch} !== '0) begin
      failures++;
      $display("FAIL midreset_clear got dout=%h v=%b gnt=%b ch=%0d required all zero",
               dout, dout_valid, gnt, dout_ch);
    end
    model_reset();
    @(negedge clock);
    req = '0;
    @(negedge clock);
    resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 4'b1111, '0, '0, eg);
      checks++;
      if (gnt !== (4'b0001 << n)) begin failures++; $display("FAIL midreset_gnt[%0d] got %b required %b", n, gnt, 4'b0001 << n); end
      @(posedge clock); #2;
      checks++;
      if (dout !== 8'hFF) begin failures++; $display("FAIL midreset_byte[%0d] got %h required FF", n, dout); end
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] eg;
    test_reset();
    test_single();
    test_round_robin();
    test_resync();
    test_enable_pause();
    test_reset_mid();
    drive(1'b1, '0, '0, '0, eg);
    drive(1'b1, '0, '0, '0, eg);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/descrambler_scheduler.md
# descrambler_scheduler

Time-shares one 8-bit additive descrambling datapath among NUM_CH byte-stream requesters. Per-channel LFSR context is held internally, so each stream descrambles exactly as if it had a private descrambler. Selection between requesters is round-robin. The block sits between the per-lane receive front-ends and the shared byte sink; it replaces per-lane descrambler instances when lane bandwidth is below one byte per clock.

## Interface
Parameters:
- NUM_CH, 4: number of requesters, 2..16
- SEED, 8'hFF: LFSR value loaded at reset and on resync
- CHW, $clog2(NUM_CH): channel index width (derived)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  global run; low freezes grants, pointer and contexts
- req  in  NUM_CH  per-channel byte request; held with din until granted
- din  in  8*NUM_CH  channel c byte on din[8c+7:8c]
- resync  in  NUM_CH  per-channel context reload to SEED
- gnt  out  NUM_CH  one-hot combinational grant; the byte is consumed this cycle
- dout  out  8  descrambled byte (registered)
- dout_valid  out  1  dout qualifier, one-cycle pulse per byte
- dout_ch  out  CHW  channel that produced dout

## Operation
- **Contexts:** ctx[0..NUM_CH-1], each 8 bits. Reset value SEED.
- **Arbitration:** round-robin pointer ptr, reset 0.
  - Requesters are searched in order ptr, ptr+1, … mod NUM_CH; the first channel with req set is granted.
  - At most one gnt bit is set per cycle.
  - gnt is all-zero when enable=0 or req=0.
- **Pointer update:** after a grant to channel k, ptr <= (k+1) mod NUM_CH. With no grant, ptr holds.
- **Granted channel k, on the clock edge:**
  - dout <= cur ^ din_k
  - ctx[k] <= {cur[6:0], cur[6]^cur[3]}
  - dout_ch <= k, dout_valid <= 1
  - cur = SEED if resync[k] is set this cycle, else ctx[k].
- **Resync on a non-granted channel:** ctx[c] <= SEED. resync acts regardless of enable.
- **No grant:** dout_valid <= 0; dout and dout_ch hold their last values.
- **Ungranted channels:** context is unchanged.
- **No request buffering:** the requester's req/din must stay stable until its gnt is seen.

## Timing
- Reset values: dout=0, dout_valid=0, dout_ch=0, gnt=0, ptr=0, all ctx=SEED.
- Latency: dout, dout_valid and dout_ch appear one clock after the gnt cycle.
- Throughput: one byte per clock in aggregate. With all requesters active, each channel gets one grant every NUM_CH cycles.
- **enable low:** gnt forced to 0; from the next edge dout_valid=0. When enable returns high, arbitration resumes from the held ptr.
- **resync[k] and gnt[k] in the same cycle:** the byte uses SEED, and ctx[k] becomes next(SEED).
- **Reset asserted mid-stream:** all state returns to reset values immediately, with no partial output.
- **ptr wrap-around:** after a grant to channel NUM_CH-1, ptr wraps to 0.

## Test plan
1. **Reset values.** Assert resetn=0 with random inputs → dout=00, dout_valid=0, gnt=0, dout_ch=0. Then, after release, ch0 with din=00 → dout=FF.
2. **Single channel, context stepping.** Hold req[2] high with din=00 for 6 cycles → gnt=0100 every cycle. One cycle later per grant: dout = FF, FE, FC, F8, F0, E1 and dout_ch=2.
3. **Round-robin with independent contexts.** All req high, all din=00 → grant order 0,1,2,3,0,1… Outputs FF,FF,FF,FF,FE,FE,FE,FE, showing each channel's context is independent.
4. **Resync.** After 3 ch0 grants, pulse resync[0] coincident with the 4th ch0 grant (din=00) → dout=FF. The following ch0 byte → FE. ch1 context is unaffected.
5. **enable pause.** Drop enable for 3 cycles mid-stream with all req high → gnt=0 and dout_valid=0. On resume, grants continue at the next channel in sequence and context values are continuous.
6. **Reset mid-operation.** Pulse resetn low asynchronously mid-stream → outputs clear at once. After release, every channel's next byte with din=00 → FF, and the first grant goes to ch0.
